serial_sub_16bit: RTL and testbench
===================================

Name: serial_sub_16bit

Overview:
- Multi-cycle subtractor computing diff = a - b - borrow_in, one SLICE-bit group per clock.
- Serves as the subtract-direction companion to the team's carry-lookahead adders; reuses the same slice arithmetic (a + ~b + carry).
- Area-lean alternative to a full-width combinational subtractor; driven by a start/busy/done handshake from the ALU control path.

Parameters:
- WIDTH, 16, operand and result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per cycle; N = WIDTH/SLICE slice cycles per operation.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- borrow_in  input  1  initial borrow.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  difference; held until the next accepted start.
- borrow_out  output  1  final borrow (1 = unsigned a < b + borrow_in).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; slice counter=0; internal operand and borrow registers=0.
- States: IDLE, RUN.
- IDLE, start=1 at an edge: latch a, b, borrow_in; clear the slice counter; set busy=1; go to RUN. done drops to 0 on this edge.
- RUN, each edge, slice i = counter:
  - {c, s} = a[i] + ~b[i] + ~brw (SLICE-bit add with carry-in).
  - Write diff slice i = s; brw <= ~c; counter++.
- Last slice edge (counter = N-1): borrow_out <= ~c; busy <= 0; done <= 1; go to IDLE.
- Latency: done is high in the cycle following the Nth edge after the start-sampling edge (N=4 for the defaults). done is high for exactly one cycle.
- Accepted-start edge: diff and borrow_out clear to 0. The partial diff is visible during RUN; it is only valid while done=1 or after done.
- start while busy=1: ignored, with no effect on the operation or operands.
- start=1 in the cycle where done=1: state is IDLE, so the start is accepted. done falls and a new operation begins (back-to-back throughput: one result per N+1 cycles).
- Inputs a, b, borrow_in: don't-care except at the accepting edge; later changes have no effect.
- Reset mid-operation: the operation is abandoned, all outputs return to reset values, and no done pulse is produced.
- Arithmetic is modulo 2^WIDTH. The final borrow equals the complement of the carry out of the top slice.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow, registered with borrow_out on the last slice edge.
  - ovf = carry into MSB XOR carry out of MSB of the top slice.
  - Reset value 0; cleared on each accepted start.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic: a=0x1234, b=0x0234, borrow_in=0, start pulse -> busy high 4 cycles; done pulse in the cycle after the 4th edge; diff=0x1000, borrow_out=0 (ovf=0).
- Wrap: a=0x0000, b=0x0001, borrow_in=0 -> diff=0xFFFF, borrow_out=1 (ovf=0).
- Borrow-in and signed overflow: a=0x8000, b=0x0000, borrow_in=1 -> diff=0x7FFF, borrow_out=0; with SERIAL_SUB_OVF_EN, ovf=1.
- Start while busy: start with a=0x00FF, b=0x000F, then assert start with a=0xFFFF, b=0xFFFF during RUN -> result diff=0x00F0, borrow_out=0; exactly one done pulse.
- Back-to-back: assert start in the done cycle with a=0x0005, b=0x0007 -> second done pulse N+1 cycles after the first; diff=0xFFFE, borrow_out=1.
- Reset mid-op: start a=0x1111, b=0x0001, drive rst_n low after 2 slice edges -> busy, done, diff and borrow_out are 0 immediately; no done pulse; a fresh start afterwards gives diff=0x1110.

Source files
------------

// File: rtl/serial_sub_16bit_if.sv
// serial_sub_16bit_if: start/busy/done handshake bundle for the serial subtractor.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_sub_16bit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             borrow_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, borrow_in, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, borrow_in, a, b,
    output busy, done, diff, borrow_out, ovf
  );
`else
  modport master (
    output start, borrow_in, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, borrow_in, a, b,
    output busy, done, diff, borrow_out
  );
`endif
endinterface

// File: rtl/serial_sub_16bit.sv
// serial_sub_16bit: multi-cycle subtractor, diff = a - b - borrow_in, one SLICE-bit
// group per clock using the same a + ~b + carry slice arithmetic as the CLA adders.
// WIDTH must be an integer multiple of SLICE.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf.
module serial_sub_16bit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic               clk,
  input logic               rst_n,
  serial_sub_16bit_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             cin_msb_s;
`endif

  int               base_s;
  logic [WIDTH-1:0] a_shift_s;
  logic [WIDTH-1:0] b_shift_s;
  logic [SLICE-1:0] a_sl_s;
  logic [SLICE-1:0] nb_sl_s;
  logic [SLICE:0]   sum_s;
  logic [SLICE-1:0] s_sl_s;
  logic             c_s;
  logic             last_s;

  // Slice datapath: select the active slice and add a + ~b + ~borrow.
  always_comb begin
    base_s    = int'(cnt_q) * SLICE;
    a_shift_s = a_q >> base_s;
    b_shift_s = b_q >> base_s;
    a_sl_s    = a_shift_s[SLICE-1:0];
    nb_sl_s   = ~b_shift_s[SLICE-1:0];
    sum_s     = {1'b0, a_sl_s} + {1'b0, nb_sl_s} + {{SLICE{1'b0}}, ~brw_q};
    s_sl_s    = sum_s[SLICE-1:0];
    c_s       = sum_s[SLICE];
    last_s    = (cnt_q == CW'(N - 1));
  end

`ifdef SERIAL_SUB_OVF_EN
  // Carry into the slice MSB, recovered from the MSB sum bit and its two addend bits.
  always_comb begin
    cin_msb_s = a_sl_s[SLICE-1] ^ nb_sl_s[SLICE-1] ^ s_sl_s[SLICE-1];
  end
`endif

  // Next-state and output logic for the IDLE/RUN controller.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    brw_d        = brw_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    busy_d       = busy_q;
    done_d       = done_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d          = bus.a;
          b_d          = bus.b;
          brw_d        = bus.borrow_in;
          cnt_d        = {CW{1'b0}};
          diff_d       = {WIDTH{1'b0}};
          borrow_out_d = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d        = 1'b0;
`endif
          state_d      = ST_RUN;
        end else begin
          // done is a single-cycle pulse; it always falls on the next idle edge.
          done_d = 1'b0;
        end
      end
      ST_RUN: begin
        diff_d = (diff_q & ~(SLICE_MASK << base_s)) |
                 ((WIDTH'(s_sl_s)) << base_s);
        brw_d  = ~c_s;
        if (last_s) begin
          borrow_out_d = ~c_s;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d        = cin_msb_s ^ c_s;
`endif
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cnt_d        = {CW{1'b0}};
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, operand and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      brw_q        <= 1'b0;
      diff_q       <= {WIDTH{1'b0}};
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      brw_q        <= brw_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_16bit.sv
// tb_serial_sub_16bit: directed-vector bench for serial_sub_16bit (WIDTH=16, SLICE=4).
// Honours SERIAL_SUB_OVF_EN when the design is built with the overflow output.
module tb_serial_sub_16bit;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_sub_16bit_if #(.WIDTH(WIDTH)) bus_if ();

  serial_sub_16bit #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int done_seen = 0;

  // Count done pulses at each rising edge (value from the preceding cycle).
  always @(posedge clk) begin
    if (bus_if.done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a start at the current negedge; returns at the negedge after the accepting edge.
  task automatic launch(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic bin);
    bus_if.start     = 1'b1;
    bus_if.a         = av;
    bus_if.b         = bv;
    bus_if.borrow_in = bin;
    @(negedge clk);
    bus_if.start     = 1'b0;
    bus_if.a         = ~av;
    bus_if.b         = ~bv;
    bus_if.borrow_in = ~bin;
    check_val({tag, "/acc_busy"}, 32'(bus_if.busy), 32'd1);
    check_val({tag, "/acc_diff"}, 32'(bus_if.diff), 32'd0);
    check_val({tag, "/acc_bo"}, 32'(bus_if.borrow_out), 32'd0);
  endtask

  // Wait (bounded) for done, check latency and results; returns at the done negedge.
  task automatic finish(input string tag, input int exp_lat, input logic [15:0] exp_diff,
                        input logic exp_bo, input logic exp_ovf);
    int n;
    n = 0;
    while (bus_if.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "/lat"}, 32'(n), 32'(exp_lat));
    check_val({tag, "/diff"}, 32'(bus_if.diff), 32'(exp_diff));
    check_val({tag, "/bo"}, 32'(bus_if.borrow_out), 32'(exp_bo));
    check_val({tag, "/busy_done"}, 32'(bus_if.busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check_val({tag, "/ovf"}, 32'(bus_if.ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
  endtask

  // Step one cycle past done and confirm the pulse fell while the result holds.
  task automatic after_done(input string tag, input logic [15:0] exp_diff);
    @(negedge clk);
    check_val({tag, "/done_fall"}, 32'(bus_if.done), 32'd0);
    check_val({tag, "/hold"}, 32'(bus_if.diff), 32'(exp_diff));
  endtask

  initial begin
    int snap;
    bus_if.start     = 1'b0;
    bus_if.borrow_in = 1'b0;
    bus_if.a         = 16'h0000;
    bus_if.b         = 16'h0000;
    rst_n            = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst/busy", 32'(bus_if.busy), 32'd0);
    check_val("rst/done", 32'(bus_if.done), 32'd0);
    check_val("rst/diff", 32'(bus_if.diff), 32'd0);
    check_val("rst/bo", 32'(bus_if.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check_val("rst/ovf", 32'(bus_if.ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: 0x1234 - 0x0234 = 0x1000.
    snap = done_seen;
    launch("basic", 16'h1234, 16'h0234, 1'b0);
    finish("basic", LAT, 16'h1000, 1'b0, 1'b0);
    after_done("basic", 16'h1000);
    check_val("basic/pulses", 32'(done_seen - snap), 32'd1);

    // Wrap: 0x0000 - 0x0001 = 0xFFFF with borrow.
    launch("wrap", 16'h0000, 16'h0001, 1'b0);
    finish("wrap", LAT, 16'hFFFF, 1'b1, 1'b0);
    after_done("wrap", 16'hFFFF);

    // Borrow-in and signed overflow: 0x8000 - 0x0000 - 1 = 0x7FFF.
    launch("brwin", 16'h8000, 16'h0000, 1'b1);
    finish("brwin", LAT, 16'h7FFF, 1'b0, 1'b1);
    after_done("brwin", 16'h7FFF);

    // Start while busy is ignored: 0x00FF - 0x000F = 0x00F0, one done pulse.
    snap = done_seen;
    launch("busy_st", 16'h00FF, 16'h000F, 1'b0);
    bus_if.start = 1'b1;
    bus_if.a     = 16'hFFFF;
    bus_if.b     = 16'hFFFF;
    @(negedge clk);
    bus_if.start = 1'b0;
    finish("busy_st", LAT - 1, 16'h00F0, 1'b0, 1'b0);
    after_done("busy_st", 16'h00F0);
    repeat (4) @(negedge clk);
    check_val("busy_st/pulses", 32'(done_seen - snap), 32'd1);
    check_val("busy_st/idle", 32'(bus_if.busy), 32'd0);

    // Back-to-back: start in the done cycle; 0x0005 - 0x0007 = 0xFFFE.
    launch("b2b1", 16'h0003, 16'h0001, 1'b0);
    finish("b2b1", LAT, 16'h0002, 1'b0, 1'b0);
    launch("b2b2", 16'h0005, 16'h0007, 1'b0);
    finish("b2b2", LAT, 16'hFFFE, 1'b1, 1'b0);
    after_done("b2b2", 16'hFFFE);

    // Reset mid-operation after two slice edges.
    launch("rstmid", 16'h1111, 16'h0001, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rstmid/busy", 32'(bus_if.busy), 32'd0);
    check_val("rstmid/done", 32'(bus_if.done), 32'd0);
    check_val("rstmid/diff", 32'(bus_if.diff), 32'd0);
    check_val("rstmid/bo", 32'(bus_if.borrow_out), 32'd0);
    snap = done_seen;
    repeat (5) @(negedge clk);
    check_val("rstmid/no_done", 32'(done_seen - snap), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    launch("fresh", 16'h1111, 16'h0001, 1'b0);
    finish("fresh", LAT, 16'h1110, 1'b0, 1'b0);
    after_done("fresh", 16'h1110);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
